vector_list_player: RTL
=======================

# vector_list_player

Display-list engine that sits between the UART receiver and the line-draw controller. It assembles UART bytes into vector commands and stores them in a double-buffered display list. It replays the committed frame continuously to the line-draw controller through its x/y/draw/jump/ready handshake, replacing the fixed four-point test pattern with host-loaded, flicker-free frames.

## Interface
- COORD_W, 12, coordinate width in bits (8..12); x/y outputs.
- ADDR_W, 8, entry address width; each bank holds DEPTH = 2**ADDR_W entries.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- rx_valid  in  1  one-cycle strobe, rx_byte valid (uart_rx o_Rx_DV).
- rx_byte  in  8  received byte.
- ready  in  1  line-draw controller can accept a command.
- x  out  COORD_W  target X, registered.
- y  out  COORD_W  target Y, registered.
- draw  out  1  one-cycle strobe: draw line to (x,y).
- jump  out  1  one-cycle strobe: move beam to (x,y) blanked.
- frame_done  out  1  one-cycle pulse after the last entry of a frame issues.
- err  out  1  sticky: entry dropped (bank full or commit pending).
- wr_count  out  ADDR_W+1  entries in the write bank.

## Operation
- Packet format: byte0 opcode in [7:6]; [5:0] ignored.
  - 00 JUMP and 01 DRAW: 4-byte packets. X12={b1,b2[7:4]}, Y12={b2[3:0],b3}. Stored coordinate = upper COORD_W bits of X12/Y12.
  - 10 COMMIT and 11 CLEAR: 1-byte packets.
- Receive assembler: byte counter 0..3. Returns to 0 after a complete packet or on reset. There is no timeout; resync is by reset only.
- Entry store: {op_is_draw, x, y} is written to write bank at address wr_count, then wr_count increments.
  - If wr_count == DEPTH or commit_pending=1: entry dropped, err<=1, wr_count unchanged.
- COMMIT: sets commit_pending.
- CLEAR: wr_count<=0, err<=0, commit_pending<=0. The displayed frame is unaffected.
- Bank swap at a frame boundary, or immediately in IDLE if disp_count==0, when commit_pending=1:
  - disp_bank toggles.
  - disp_count<=wr_count.
  - wr_count<=0.
  - commit_pending<=0.
- Player FSM:
  - IDLE: rd_idx<=0. Waits for disp_count!=0.
  - FETCH: synchronous RAM read of entry rd_idx (1-cycle latency).
  - READY_WAIT: waits for ready=1.
  - ISSUE: loads x,y and pulses draw or jump for exactly one cycle.
  - GUARD: one idle cycle so the controller can drop ready.
    - If rd_idx == disp_count-1: frame_done pulse, swap check, rd_idx<=0, then FETCH (or IDLE if disp_count becomes 0).
    - Else: rd_idx+1, then FETCH.
- A frame replays indefinitely until a new commit swaps banks.
- draw and jump are never high together.
- Reset mid-operation: FSM to IDLE, both counts 0, bank 0 displayed, strobes low. RAM contents are don't-care.

## Timing
- Reset values: x=0, y=0, draw=0, jump=0, frame_done=0, err=0, wr_count=0. Internal: commit_pending=0, disp_count=0, byte counter 0.
- Entry write occurs the cycle after the 4th rx_valid; wr_count updates that cycle.
- Command issue: FETCH→READY_WAIT→ISSUE takes at least 3 cycles per entry plus GUARD, so the minimum spacing between strobes is 4 cycles.
- x/y change only in the ISSUE cycle and hold until the next ISSUE.
- The controller must deassert ready within one cycle of a strobe. The player ignores ready outside READY_WAIT.
- COMMIT arriving in the same cycle as the GUARD frame-end check: not taken for that frame. It swaps at the next frame end.
- COMMIT and CLEAR in consecutive bytes before the swap: CLEAR wins; no swap occurs.
- frame_done asserts in the GUARD cycle of the last entry. Swap results are visible the next cycle.

## Test plan
- Load JUMP(4095,400), DRAW(0,3695), DRAW(4095,4095), DRAW(0,0), then COMMIT.
  - Required: the strobe sequence jump,draw,draw,draw with matching x/y, repeating.
  - Required: frame_done once per 4 strobes.
  - Required: ready held high gives strobes exactly 4 cycles apart.
- While frame A (2 entries) plays, load frame B (3 entries) and COMMIT mid-frame.
  - Required: A completes fully, then B starts at entry 0.
  - Required: wr_count returns to 0 after the swap.
- With ADDR_W=2, send 5 entries.
  - Required: wr_count=4, err=1, 5th entry never issued.
  - Then CLEAR: err=0, wr_count=0.
- Send 2 entries, COMMIT, then 1 entry before the swap.
  - Required: 3rd entry dropped, err=1; displayed frame has 2 entries.
- Hold ready low for 50 cycles during READY_WAIT.
  - Required: no strobe, x/y stable.
  - Release ready: exactly one strobe after 1 cycle.
- Assert reset mid-packet (after 2 bytes) and mid-frame.
  - Required: all outputs at reset values next cycle.
  - Required: a new 4-byte packet after reset is assembled correctly.

Source files
------------

// File: rtl/vector_list_player.sv
// vector_list_player: assembles UART bytes into vector commands in a
// double-buffered display list and replays the shown frame to the line drawer.
module vector_list_player #(
  parameter int COORD_W = 12,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  output logic               frame_done,
  output logic               err,
  output logic [ADDR_W:0]    wr_count
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int ENT_W = 1 + 2*COORD_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, FETCH, READY_WAIT, ISSUE, GUARD
  } state_t;

  state_t state, state_nx;

  logic [1:0]        byte_cnt;
  logic              op_draw;
  logic [7:0]        b1, b2;
  logic              commit_pending;
  logic              disp_bank;
  logic [ADDR_W:0]   disp_count;
  logic [ADDR_W:0]   disp_last;
  logic [ADDR_W-1:0] rd_idx;
  logic [ENT_W-1:0]  mem [2*DEPTH];
  logic [ENT_W-1:0]  rd_data;

  logic [11:0] x12, y12;
  logic pkt_done, is_commit, is_clear, wr_ok;
  logic last, swap;
  logic ld_xy, draw_nx, jump_nx, done_nx;

  assign x12       = {b1, b2[7:4]};
  assign y12       = {b2[3:0], rx_byte};
  assign pkt_done  = rx_valid && (byte_cnt == 2'd3);
  assign is_commit = rx_valid && (byte_cnt == 2'd0)
                     && (rx_byte[7:6] == 2'b10);
  assign is_clear  = rx_valid && (byte_cnt == 2'd0)
                     && (rx_byte[7:6] == 2'b11);
  assign wr_ok     = pkt_done && !commit_pending
                     && (wr_count != FULL);
  assign disp_last = disp_count - 1'b1;
  assign last      = ({1'b0, rd_idx} == disp_last);

  // Swap only where no entry of the shown frame is in flight.
  assign swap = commit_pending
                && (((state == GUARD) && last)
                    || ((state == IDLE) && (disp_count == '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt       <= 2'd0;
      op_draw        <= 1'b0;
      b1             <= '0;
      b2             <= '0;
      wr_count       <= '0;
      err            <= 1'b0;
      commit_pending <= 1'b0;
      disp_bank      <= 1'b0;
      disp_count     <= '0;
    end else begin
      if (rx_valid) begin
        unique case (byte_cnt)
          2'd0: begin
            op_draw  <= rx_byte[6];
            byte_cnt <= rx_byte[7] ? 2'd0 : 2'd1;
          end
          2'd1: begin
            b1       <= rx_byte;
            byte_cnt <= 2'd2;
          end
          2'd2: begin
            b2       <= rx_byte;
            byte_cnt <= 2'd3;
          end
          default: byte_cnt <= 2'd0;
        endcase
      end
      if (swap) begin
        disp_bank      <= ~disp_bank;
        disp_count     <= wr_count;
        wr_count       <= '0;
        commit_pending <= 1'b0;
      end
      if (pkt_done) begin
        if (wr_ok) wr_count <= wr_count + 1'b1;
        else       err      <= 1'b1;
      end
      if (is_commit) commit_pending <= 1'b1;
      if (is_clear) begin
        wr_count       <= '0;
        err            <= 1'b0;
        commit_pending <= 1'b0;
      end
    end
  end

  // Write bank is always the one not on display.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[{~disp_bank, wr_count[ADDR_W-1:0]}] <=
        {op_draw, x12[11 -: COORD_W], y12[11 -: COORD_W]};
    if (state == FETCH)
      rd_data <= mem[{disp_bank, rd_idx}];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (disp_count != '0) state_nx = FETCH;
      FETCH:      state_nx = READY_WAIT;
      READY_WAIT: if (ready) state_nx = ISSUE;
      ISSUE:      state_nx = GUARD;
      GUARD: begin
        if (last && swap && (wr_count == '0)) state_nx = IDLE;
        else                                  state_nx = FETCH;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_xy   = 1'b0;
    draw_nx = 1'b0;
    jump_nx = 1'b0;
    done_nx = 1'b0;
    unique case (state)
      READY_WAIT: begin
        if (ready) begin
          ld_xy   = 1'b1;
          draw_nx = rd_data[ENT_W-1];
          jump_nx = !rd_data[ENT_W-1];
        end
      end
      ISSUE:   done_nx = last;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      rd_idx     <= '0;
    end else begin
      draw       <= draw_nx;
      jump       <= jump_nx;
      frame_done <= done_nx;
      if (ld_xy) begin
        x <= rd_data[2*COORD_W-1 -: COORD_W];
        y <= rd_data[COORD_W-1:0];
      end
      if ((state == IDLE) || ((state == GUARD) && last))
        rd_idx <= '0;
      else if (state == GUARD)
        rd_idx <= rd_idx + 1'b1;
    end
  end

endmodule
